motion_update_broadcast: RTL

//   Upstream motion-update engine for the per-cell velocity and position caches.

---
 rtl/motion_update_broadcast.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/motion_update_broadcast.sv
// motion_update_broadcast: walks every source cell, integrates v' = v + f*dt and p' = p + v'*dt, broadcasts {v', p', dst_cell}.
// Latency: read address issued at t, cache data at t+2, registered broadcast word with out_data_valid at t+3; 1 particle/cycle.
// Backpressure: none; destination caches must take every word while motion_update_enable is high. Option macro: VELOCITY_SATURATE_EN.
module motion_update_broadcast #(
   parameter int DATA_WIDTH    = 32,
   parameter int PARTICLE_NUM  = 220,
   parameter int ADDR_WIDTH    = 8,
   parameter int CELL_ID_WIDTH = 4,
   parameter int NUM_CELLS     = 64,
   parameter int DT_SHIFT      = 8,
   parameter int CELL_W        = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic [CELL_W-1:0]          out_src_cell,
   output logic [ADDR_WIDTH-1:0]      out_rd_address,
   output logic                       out_rden,
   input  logic [3*DATA_WIDTH-1:0]    in_velocity,
   input  logic [3*DATA_WIDTH-1:0]    in_force,
   input  logic [3*DATA_WIDTH-1:0]    in_position,
   output logic                       motion_update_enable,
   output logic [3*DATA_WIDTH-1:0]    out_velocity,
   output logic [3*DATA_WIDTH-1:0]    out_position,
   output logic [3*CELL_ID_WIDTH-1:0] out_dst_cell,
   output logic                       out_data_valid,
   output logic                       done
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_REQ_NUM = 3'd1;
   localparam logic [2:0] S_STREAM  = 3'd2;
   localparam logic [2:0] S_DRAIN   = 3'd3;
   localparam logic [2:0] S_NEXT    = 3'd4;
   localparam logic [2:0] S_FINISH  = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   localparam logic [ADDR_WIDTH-1:0] MAX_CNT   = ADDR_WIDTH'(PARTICLE_NUM);
   localparam logic [CELL_W-1:0]     LAST_CELL = CELL_W'(NUM_CELLS - 1);

   logic [2:0]                 r_state;
   logic [CELL_W-1:0]          r_cell;
   logic [ADDR_WIDTH-1:0]      r_addr;
   logic [ADDR_WIDTH-1:0]      r_count;
   logic [1:0]                 r_wait;
   logic                       r_rden;
   logic                       r_enable;
   logic                       r_done;
   logic                       r_vld_d1;
   logic                       r_vld_d2;
   logic                       r_out_vld;
   logic [3*DATA_WIDTH-1:0]    r_out_vel;
   logic [3*DATA_WIDTH-1:0]    r_out_pos;
   logic [3*CELL_ID_WIDTH-1:0] r_out_dst;

   logic [ADDR_WIDTH-1:0]      w_count;
   logic [3*DATA_WIDTH-1:0]    w_vel_new;
   logic [3*DATA_WIDTH-1:0]    w_pos_new;
   logic [3*CELL_ID_WIDTH-1:0] w_dst;

   // v' = v + (f >>> DT_SHIFT); either wraps or clamps to the signed range
   function automatic logic [DATA_WIDTH-1:0] vel_step(input logic [DATA_WIDTH-1:0] v,
                                                      input logic [DATA_WIDTH-1:0] f);
      logic signed [DATA_WIDTH-1:0] f_sh;
`ifdef VELOCITY_SATURATE_EN
      logic signed [DATA_WIDTH:0] sum;
      f_sh = $signed(f) >>> DT_SHIFT;
      sum  = $signed({v[DATA_WIDTH-1], v}) + $signed({f_sh[DATA_WIDTH-1], f_sh});
      if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
         return sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else
         return sum[DATA_WIDTH-1:0];
`else
      logic signed [DATA_WIDTH-1:0] sum;
      f_sh = $signed(f) >>> DT_SHIFT;
      sum  = $signed(v) + f_sh;
      return sum;
`endif
   endfunction

   // Per-component datapath; position always wraps, which gives the periodic boundary
   for (genvar k = 0; k < 3; k++) begin : g_comp
      logic signed [DATA_WIDTH-1:0] w_v_sh;
      assign w_vel_new[k*DATA_WIDTH +: DATA_WIDTH] =
         vel_step(in_velocity[k*DATA_WIDTH +: DATA_WIDTH], in_force[k*DATA_WIDTH +: DATA_WIDTH]);
      assign w_v_sh = $signed(w_vel_new[k*DATA_WIDTH +: DATA_WIDTH]) >>> DT_SHIFT;
      assign w_pos_new[k*DATA_WIDTH +: DATA_WIDTH] = in_position[k*DATA_WIDTH +: DATA_WIDTH] + w_v_sh;
   end

   // Destination cell is {x, y, z}, each the top bits of the new position component
   assign w_dst = {w_pos_new[DATA_WIDTH-1 -: CELL_ID_WIDTH],
                   w_pos_new[2*DATA_WIDTH-1 -: CELL_ID_WIDTH],
                   w_pos_new[3*DATA_WIDTH-1 -: CELL_ID_WIDTH]};

   // Count word: only the low address bits matter, clamped to the cache capacity
   assign w_count = (in_position[ADDR_WIDTH-1:0] > MAX_CNT) ? MAX_CNT : in_position[ADDR_WIDTH-1:0];

   // Sweep controller: cell walk, count fetch, address streaming and drain
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cell   <= '0;
         r_addr   <= '0;
         r_count  <= '0;
         r_wait   <= '0;
         r_rden   <= 1'b0;
         r_enable <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state  <= S_REQ_NUM;
                  r_cell   <= '0;
                  r_enable <= 1'b1;
                  r_rden   <= 1'b1;
                  r_addr   <= '0;
                  r_wait   <= '0;
               end
            end
            S_REQ_NUM: begin
               r_rden <= 1'b0;
               if (r_wait == 2'd2) begin
                  r_count <= w_count;
                  if (w_count == '0) begin
                     r_state <= S_NEXT;
                  end else begin
                     r_state <= S_STREAM;
                     r_rden  <= 1'b1;
                     r_addr  <= ADDR_WIDTH'(1);
                  end
               end else begin
                  r_wait <= r_wait + 2'd1;
               end
            end
            S_STREAM: begin
               if (r_addr == r_count) begin
                  r_rden  <= 1'b0;
                  r_addr  <= '0;
                  r_wait  <= '0;
                  r_state <= S_DRAIN;
               end else begin
                  r_addr <= r_addr + ADDR_WIDTH'(1);
               end
            end
            S_DRAIN: begin
               // last word leaves the output register during the third drain cycle
               if (r_wait == 2'd2) r_state <= S_NEXT;
               else                r_wait  <= r_wait + 2'd1;
            end
            S_NEXT: begin
               if (r_cell == LAST_CELL) begin
                  r_state <= S_FINISH;
               end else begin
                  r_cell  <= r_cell + CELL_W'(1);
                  r_state <= S_REQ_NUM;
                  r_rden  <= 1'b1;
                  r_addr  <= '0;
                  r_wait  <= '0;
               end
            end
            S_FINISH: begin
               r_enable <= 1'b0;
               r_state  <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Particle-read tracker matching the 2-cycle cache latency (count reads excluded)
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_vld_d1 <= 1'b0;
         r_vld_d2 <= 1'b0;
      end else begin
         r_vld_d1 <= r_rden && (r_addr != '0);
         r_vld_d2 <= r_vld_d1;
      end
   end

   // Broadcast register; data forced to zero when not qualified
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_out_vld <= 1'b0;
         r_out_vel <= '0;
         r_out_pos <= '0;
         r_out_dst <= '0;
      end else begin
         r_out_vld <= r_vld_d2;
         r_out_vel <= r_vld_d2 ? w_vel_new : '0;
         r_out_pos <= r_vld_d2 ? w_pos_new : '0;
         r_out_dst <= r_vld_d2 ? w_dst     : '0;
      end
   end

   assign out_src_cell         = r_cell;
   assign out_rd_address       = r_addr;
   assign out_rden             = r_rden;
   assign motion_update_enable = r_enable;
   assign out_velocity         = r_out_vel;
   assign out_position         = r_out_pos;
   assign out_dst_cell         = r_out_dst;
   assign out_data_valid       = r_out_vld;
   assign done                 = r_done;

endmodule
